lcd_pixel_reader: RTL and testbench

//  Read-back path for the ILI9341/ILI9488 8080-style 8-bit parallel bus: the inverse of gpu color expansion.

---
 rtl/lcd_pixel_reader.sv | 130 +++++++++++++
 tb/tb_lcd_pixel_reader.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/lcd_pixel_reader.sv
// Read-back path for an 8080-style 8-bit LCD bus: strobes RDX, assembles RGB666
// pixels and packs key-color matches into a 1bpp mono word (LSB = first pixel).
module lcd_pixel_reader #(
    parameter int WIDTH = 18,
    parameter int RDL   = 4,
    parameter int RDH   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       sel,
    input  logic             go,
    output logic             busy,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] a,
    input  logic [7:0]       lcd_d,
    output logic             lcd_rd_n,
    output logic             lcd_rden
);
    localparam int CMAX = (RDL > RDH) ? RDL : RDH;
    localparam int CW   = $clog2(CMAX + 1);

    // ONE covers the single-cycle register commands (SETKEY, GETMONO)
    typedef enum logic [1:0] {IDLE, ONE, LOW, HIGH} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [1:0]       left, left_d;
    logic [1:0]       cmd;
    logic [17:0]      key;
    logic [17:0]      pix_sr;
    logic [WIDTH-1:0] mono;
    logic             launch, cap, done;

    logic unused_ok;
    assign unused_ok = &{1'b0, lcd_d[1:0]};

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        left_d  = left;
        launch  = 1'b0;
        cap     = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: if (go) begin
                launch = 1'b1;
                if (sel == 2'd1 || sel == 2'd2) begin
                    state_d = LOW;
                    cnt_d   = CW'(RDL - 1);
                    left_d  = (sel == 2'd2) ? 2'd2 : 2'd0;
                end else begin
                    state_d = ONE;
                end
            end
            ONE: begin
                state_d = IDLE;
                done    = 1'b1;
            end
            LOW: if (cnt == '0) begin
                cap     = 1'b1;
                state_d = HIGH;
                cnt_d   = CW'(RDH - 1);
            end else begin
                cnt_d = cnt - 1'b1;
            end
            HIGH: if (cnt == '0) begin
                if (left != 2'd0) begin
                    state_d = LOW;
                    cnt_d   = CW'(RDL - 1);
                    left_d  = left - 1'b1;
                end else begin
                    state_d = IDLE;
                    done    = 1'b1;
                end
            end else begin
                cnt_d = cnt - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes come straight from flops so RDX cannot glitch on multi-bit state changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            left     <= 2'd0;
            busy     <= 1'b0;
            lcd_rd_n <= 1'b1;
            lcd_rden <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            left     <= left_d;
            busy     <= (state_d != IDLE);
            lcd_rd_n <= (state_d != LOW);
            lcd_rden <= (state_d == LOW) || (state_d == HIGH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd    <= 2'd0;
            key    <= '0;
            pix_sr <= '0;
            mono   <= '0;
            y      <= '0;
        end else begin
            if (launch) begin
                cmd <= sel;
                if (sel == 2'd0)
                    key <= a[17:0];
            end
            // Three shifts fully overwrite the register, so no stale bytes survive
            if (cap)
                pix_sr <= {pix_sr[11:0], lcd_d[7:2]};
            if (done) begin
                case (cmd)
                    2'd1: mono <= '0;
                    2'd2: begin
                        y    <= WIDTH'(pix_sr);
                        mono <= {pix_sr == key, mono[WIDTH-1:1]};
                    end
                    2'd3: y <= mono;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lcd_pixel_reader.sv
// Self-checking bench for lcd_pixel_reader: table-driven pixel reads, a y scoreboard,
// and hand sequences for mono packing, go-while-busy and mid-transaction reset.
module tb_lcd_pixel_reader;
    localparam int W   = 18;
    localparam int RDL = 4;
    localparam int RDH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   sel;
    logic         go;
    logic         busy;
    logic [W-1:0] y;
    logic [W-1:0] a;
    logic [7:0]   lcd_d = 8'h00;
    logic         lcd_rd_n;
    logic         lcd_rden;

    lcd_pixel_reader #(.WIDTH(W), .RDL(RDL), .RDH(RDH)) dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .go(go), .busy(busy), .y(y), .a(a),
        .lcd_d(lcd_d), .lcd_rd_n(lcd_rd_n), .lcd_rden(lcd_rden)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    int lowcyc = 0;
    int rdencyc = 0;

    logic [7:0]  bus_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] key_m, mono_m, y_m;

    // LCD model: present the next queued byte for each RDX pulse
    always @(negedge lcd_rd_n) begin
        pulses <= pulses + 1;
        if (bus_q.size() > 0) lcd_d <= bus_q.pop_front();
        else lcd_d <= 8'h00;
    end

    always @(negedge clk) begin
        if (!lcd_rd_n) lowcyc <= lowcyc + 1;
        if (lcd_rden) rdencyc <= rdencyc + 1;
    end

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [17:0] exp_y;
    } vec_t;
    vec_t tab[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] s, input logic [17:0] av,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input bit dbl);
        int n, exp_busy, bc, p0, l0, r0;
        logic [17:0] pix;
        n = (s == 2'd1) ? 1 : (s == 2'd2) ? 3 : 0;
        exp_busy = (n > 0) ? n * (RDL + RDH) : 1;
        pix = {b0[7:2], b1[7:2], b2[7:2]};
        if (s == 2'd1) bus_q.push_back(b0);
        if (s == 2'd2) begin bus_q.push_back(b0); bus_q.push_back(b1); bus_q.push_back(b2); end
        case (s)
            2'd0: key_m = av;
            2'd1: mono_m = '0;
            2'd2: begin mono_m = {pix == key_m, mono_m[17:1]}; y_m = pix; end
            default: y_m = mono_m;
        endcase
        exp_q.push_back(y_m);
        @(negedge clk);
        p0 = pulses; l0 = lowcyc; r0 = rdencyc;
        sel = s; a = av; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        bc = 0;
        while (busy && bc < 1000) begin
            bc++;
            go = dbl && (bc == 3);
            @(negedge clk);
        end
        go = 1'b0;
        #1;
        check("busy_len", bc, exp_busy);
        check("rdx_pulses", pulses - p0, n);
        check("rdx_low_cycles", lowcyc - l0, n * RDL);
        check("rden_cycles", rdencyc - r0, n * (RDL + RDH));
        check("y", y, exp_q.pop_front());
        if (dbl) begin
            @(negedge clk);
            check("no_queued_go", busy, 1'b0);
        end
    endtask

    initial begin
        tab[0] = '{8'hFC, 8'h00, 8'hFC, 18'h3F03F};
        tab[1] = '{8'hFF, 8'h03, 8'h80, 18'h3F020};
        tab[2] = '{8'hFE, 8'h01, 8'h7F, 18'h3F01F};
        tab[3] = '{8'h00, 8'h00, 8'h00, 18'h00000};
        tab[4] = '{8'h84, 8'h48, 8'hC0, 18'h214B0};
        key_m = '0; mono_m = '0; y_m = '0;
        rst_n = 1'b0; go = 1'b0; sel = 2'd0; a = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_y", y, 18'h0);
        check("rst_rd_n", lcd_rd_n, 1'b1);
        check("rst_rden", lcd_rden, 1'b0);
        rst_n = 1'b1;

        run_cmd(2'd3, '0, 8'h00, 8'h00, 8'h00, 1'b0);
        run_cmd(2'd0, 18'h3F03F, 8'h00, 8'h00, 8'h00, 1'b0);
        run_cmd(2'd1, '0, 8'hAA, 8'h00, 8'h00, 1'b0);
        run_cmd(2'd3, '0, 8'h00, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_cmd(2'd2, '0, tab[i].b0, tab[i].b1, tab[i].b2, 1'b0);
            check("tab_y", y, tab[i].exp_y);
            if (i == 0) begin
                run_cmd(2'd3, '0, 8'h00, 8'h00, 8'h00, 1'b0);
                check("mono_msb", y[17], 1'b1);
            end
        end
        run_cmd(2'd3, '0, 8'h00, 8'h00, 8'h00, 1'b0);

        run_cmd(2'd1, '0, 8'h55, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < W; i++) begin
            if (i % 2 == 0) run_cmd(2'd2, '0, 8'hFC, 8'h00, 8'hFC, 1'b0);
            else run_cmd(2'd2, '0, 8'h00, 8'h00, 8'h00, 1'b0);
        end
        run_cmd(2'd3, '0, 8'h00, 8'h00, 8'h00, 1'b0);
        check("mono_pattern", y, 18'h15555);

        run_cmd(2'd2, '0, 8'h84, 8'h48, 8'hC0, 1'b1);

        begin : mid_reset
            int p0, g;
            bus_q.push_back(8'hFC); bus_q.push_back(8'hFC); bus_q.push_back(8'hFC);
            @(negedge clk);
            p0 = pulses;
            sel = 2'd2; go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            g = 0;
            while (pulses - p0 < 2 && g < 200) begin g++; @(negedge clk); end
            check("reached_byte1", pulses - p0, 2);
            @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            check("abort_rd_n", lcd_rd_n, 1'b1);
            check("abort_busy", busy, 1'b0);
            check("abort_rden", lcd_rden, 1'b0);
            check("abort_y", y, 18'h0);
            @(negedge clk);
            rst_n = 1'b1;
            bus_q.delete();
            exp_q.delete();
            key_m = '0; mono_m = '0; y_m = '0;
        end
        run_cmd(2'd2, '0, 8'h54, 8'hA8, 8'h0C, 1'b0);
        check("clean_pixel", y, 18'h15A83);
        run_cmd(2'd3, '0, 8'h00, 8'h00, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
